// File: rtl/result_pkt_serializer_pkg.sv
// Shared constants for the result packet serializer: input type codes,
// wire type codes, word counts and FSM state encoding.
package result_pkt_serializer_pkg;

    localparam logic [2:0] PKT_TYPE_CMP_EQUAL       = 3'd1;
    localparam logic [2:0] PKT_TYPE_PROCESSING_DONE = 3'd2;

    localparam logic [7:0] OUTPKT_TYPE_CMP_EQUAL_DEF       = 8'hD4;
    localparam logic [7:0] OUTPKT_TYPE_PROCESSING_DONE_DEF = 8'hD2;
    localparam logic [7:0] VERSION_DEF                     = 8'h02;

    localparam logic [1:0] HDR_LAST       = 2'd3;
    localparam logic [1:0] CSUM_LAST      = 2'd1;
    localparam logic [1:0] BODY_LAST_CMP  = 2'd3;
    localparam logic [1:0] BODY_LAST_DONE = 2'd1;

    localparam logic [23:0] DATA_LEN_CMP  = 24'd8;
    localparam logic [23:0] DATA_LEN_DONE = 24'd4;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_HCSUM = 3'd2;
    localparam logic [2:0] ST_BODY  = 3'd3;
    localparam logic [2:0] ST_BCSUM = 3'd4;

endpackage

// File: rtl/outpkt_checksum32.sv
// 32-bit checksum accumulator fed 16-bit words, low word of each pair first;
// output is the bitwise inverse of the running sum.
module outpkt_checksum32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [15:0] din,
    output logic [31:0] csum
);

    logic [31:0] acc_q, acc_d;
    logic [15:0] lo_q, lo_d;
    logic        odd_q, odd_d;

    always_comb begin
        acc_d = acc_q;
        lo_d  = lo_q;
        odd_d = odd_q;
        if (clr) begin
            acc_d = '0;
            lo_d  = '0;
            odd_d = 1'b0;
        end else if (en) begin
            if (odd_q) begin
                acc_d = acc_q + {din, lo_q};
                odd_d = 1'b0;
            end else begin
                lo_d  = din;
                odd_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            lo_q  <= '0;
            odd_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            odd_q <= odd_d;
        end
    end

    assign csum = ~acc_q;

endmodule

// File: rtl/result_pkt_serializer.sv
// Serializes one captured result record into a 16-bit word packet with
// independent header and body checksums.
module result_pkt_serializer
    import result_pkt_serializer_pkg::*;
#(
    parameter int          HASH_NUM_MSB                = 15,
    parameter logic [7:0]  VERSION                     = VERSION_DEF,
    parameter logic [7:0]  OUTPKT_TYPE_CMP_EQUAL       = OUTPKT_TYPE_CMP_EQUAL_DEF,
    parameter logic [7:0]  OUTPKT_TYPE_PROCESSING_DONE = OUTPKT_TYPE_PROCESSING_DONE_DEF
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  wr_en,
    output logic                  full,
    input  logic [2:0]            pkt_type,
    input  logic [15:0]           pkt_id,
    input  logic [31:0]           gen_id,
    input  logic [15:0]           word_id,
    input  logic [31:0]           num_processed,
    input  logic [HASH_NUM_MSB:0] hash_num,
    output logic [15:0]           dout,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  err_type
);

    logic [2:0]            state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic                  full_q, full_d;
    logic                  err_q, err_d;
    logic                  is_cmp_q, is_cmp_d;
    logic [15:0]           pkt_id_q, pkt_id_d;
    logic [31:0]           gen_id_q, gen_id_d;
    logic [15:0]           word_id_q, word_id_d;
    logic [31:0]           num_proc_q, num_proc_d;
    logic [HASH_NUM_MSB:0] hash_q, hash_d;

    logic        pop, accept, type_ok;
    logic        csum_clr, csum_en;
    logic [31:0] csum;
    logic [15:0] word;
    logic [15:0] hash_ext;
    logic [23:0] data_len;
    logic [7:0]  type_code;
    logic [1:0]  body_last;

    assign pop     = rd_en & (state_q != ST_IDLE);
    assign accept  = wr_en & ~full_q;
    assign type_ok = (pkt_type == PKT_TYPE_CMP_EQUAL)
                   | (pkt_type == PKT_TYPE_PROCESSING_DONE);

    always_comb begin
        is_cmp_d   = is_cmp_q;
        pkt_id_d   = pkt_id_q;
        gen_id_d   = gen_id_q;
        word_id_d  = word_id_q;
        num_proc_d = num_proc_q;
        hash_d     = hash_q;
        err_d      = err_q;
        if (accept) begin
            is_cmp_d   = (pkt_type == PKT_TYPE_CMP_EQUAL);
            pkt_id_d   = pkt_id;
            gen_id_d   = gen_id;
            word_id_d  = word_id;
            num_proc_d = num_processed;
            hash_d     = hash_num;
            err_d      = err_q | ~type_ok;
        end
    end

    assign body_last = is_cmp_q ? BODY_LAST_CMP : BODY_LAST_DONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        full_d  = full_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (full_q) state_d = ST_HDR;
                if (accept && type_ok) full_d = 1'b1;
            end
            ST_HDR: if (pop) begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == HDR_LAST) begin
                    state_d = ST_HCSUM;
                    cnt_d   = '0;
                end
            end
            ST_HCSUM: if (pop) begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == CSUM_LAST) begin
                    state_d = ST_BODY;
                    cnt_d   = '0;
                end
            end
            ST_BODY: if (pop) begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == body_last) begin
                    state_d = ST_BCSUM;
                    cnt_d   = '0;
                end
            end
            ST_BCSUM: if (pop) begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == CSUM_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    full_d  = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                full_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        hash_ext                 = '0;
        hash_ext[HASH_NUM_MSB:0] = hash_q;
        data_len  = is_cmp_q ? DATA_LEN_CMP : DATA_LEN_DONE;
        type_code = is_cmp_q ? OUTPKT_TYPE_CMP_EQUAL
                             : OUTPKT_TYPE_PROCESSING_DONE;
        word = '0;
        case (state_q)
            ST_HDR: begin
                case (cnt_q)
                    2'd0:    word = {type_code, VERSION};
                    2'd1:    word = data_len[15:0];
                    2'd2:    word = {8'h00, data_len[23:16]};
                    default: word = pkt_id_q;
                endcase
            end
            ST_HCSUM, ST_BCSUM: word = cnt_q[0] ? csum[31:16] : csum[15:0];
            ST_BODY: begin
                if (is_cmp_q) begin
                    case (cnt_q)
                        2'd0:    word = word_id_q;
                        2'd1:    word = gen_id_q[15:0];
                        2'd2:    word = gen_id_q[31:16];
                        default: word = hash_ext;
                    endcase
                end else begin
                    word = cnt_q[0] ? num_proc_q[31:16] : num_proc_q[15:0];
                end
            end
            default: word = '0;
        endcase
    end

    // header sum is held through HCSUM, then cleared for the body
    assign csum_en  = pop & ((state_q == ST_HDR) | (state_q == ST_BODY));
    assign csum_clr = (state_q == ST_IDLE)
                    | (pop & (state_q == ST_HCSUM) & (cnt_q == CSUM_LAST));

    outpkt_checksum32 u_csum (
        .clk  (CLK),
        .rst  (rst),
        .clr  (csum_clr),
        .en   (csum_en),
        .din  (word),
        .csum (csum)
    );

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            full_q     <= 1'b0;
            err_q      <= 1'b0;
            is_cmp_q   <= 1'b0;
            pkt_id_q   <= '0;
            gen_id_q   <= '0;
            word_id_q  <= '0;
            num_proc_q <= '0;
            hash_q     <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            err_q      <= err_d;
            is_cmp_q   <= is_cmp_d;
            pkt_id_q   <= pkt_id_d;
            gen_id_q   <= gen_id_d;
            word_id_q  <= word_id_d;
            num_proc_q <= num_proc_d;
            hash_q     <= hash_d;
        end
    end

    assign full     = full_q;
    assign empty    = (state_q == ST_IDLE);
    assign dout     = word;
    assign err_type = err_q;

endmodule

// File: tb/tb_result_pkt_serializer.sv
// Scoreboard bench for result_pkt_serializer: expected words are queued
// when a record is driven and compared as the DUT presents them.
module tb_result_pkt_serializer;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [2:0]  pkt_type = '0;
    logic [15:0] pkt_id = '0;
    logic [31:0] gen_id = '0;
    logic [15:0] word_id = '0;
    logic [31:0] num_processed = '0;
    logic [15:0] hash_num = '0;
    logic        full, empty, err_type;
    logic [15:0] dout;

    int vectors = 0;
    int miscompares = 0;
    logic [15:0] exp_q[$];

    result_pkt_serializer dut (
        .CLK           (CLK),
        .rst           (rst),
        .wr_en         (wr_en),
        .full          (full),
        .pkt_type      (pkt_type),
        .pkt_id        (pkt_id),
        .gen_id        (gen_id),
        .word_id       (word_id),
        .num_processed (num_processed),
        .hash_num      (hash_num),
        .dout          (dout),
        .rd_en         (rd_en),
        .empty         (empty),
        .err_type      (err_type)
    );

    always #5 CLK = ~CLK;

    // Reference packet builder, independent of the RTL structure.
    task automatic push_pkt(input logic [2:0] t, input logic [15:0] id,
                            input logic [31:0] gen, input logic [15:0] wid,
                            input logic [31:0] np, input logic [15:0] hn);
        logic [15:0] h[4];
        logic [15:0] b[4];
        logic [31:0] s;
        int nb;
        h[0] = {(t == 3'd1) ? 8'hD4 : 8'hD2, 8'h02};
        h[1] = (t == 3'd1) ? 16'd8 : 16'd4;
        h[2] = 16'h0000;
        h[3] = id;
        if (t == 3'd1) begin
            b[0] = wid; b[1] = gen[15:0]; b[2] = gen[31:16]; b[3] = hn;
            nb = 4;
        end else begin
            b[0] = np[15:0]; b[1] = np[31:16]; b[2] = '0; b[3] = '0;
            nb = 2;
        end
        s = ~({h[1], h[0]} + {h[3], h[2]});
        for (int i = 0; i < 4; i++) exp_q.push_back(h[i]);
        exp_q.push_back(s[15:0]);
        exp_q.push_back(s[31:16]);
        s = '0;
        for (int i = 0; i < nb; i += 2) s = s + {b[i+1], b[i]};
        s = ~s;
        for (int i = 0; i < nb; i++) exp_q.push_back(b[i]);
        exp_q.push_back(s[15:0]);
        exp_q.push_back(s[31:16]);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [2:0] t, input logic [15:0] id,
                        input logic [31:0] gen, input logic [15:0] wid,
                        input logic [31:0] np, input logic [15:0] hn);
        wr_en = 1'b1; pkt_type = t; pkt_id = id; gen_id = gen;
        word_id = wid; num_processed = np; hash_num = hn;
        if (t == 3'd1 || t == 3'd2) push_pkt(t, id, gen, wid, np, hn);
        @(negedge CLK);
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge CLK);
        vectors++;
        if (full !== 1'b0 || empty !== 1'b1 || dout !== 16'h0 || err_type !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: full=%b empty=%b dout=%h err=%b want 0 1 0000 0",
                     full, empty, dout, err_type);
        end
        rst = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_cmp_equal();
        rd_en = 1'b1;
        send(3'd1, 16'h1234, 32'hAABBCCDD, 16'h0005, 32'h0, 16'h0003);
        vectors++;
        if (full !== 1'b1 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL cmp_accept: full=%b empty=%b want 1 1", full, empty);
        end
        @(negedge CLK);
        vectors++;
        if (empty !== 1'b0) begin
            miscompares++;
            $display("FAIL cmp_latency: empty=%b want 0", empty);
        end
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            if (!empty) begin
                vectors++;
                if (dout !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL cmp_word: dout=%h want %h", dout, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            @(negedge CLK);
        end
        vectors++;
        if (exp_q.size() != 0 || full !== 1'b0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL cmp_release: left=%0d full=%b empty=%b want 0 0 1",
                     exp_q.size(), full, empty);
            exp_q.delete();
        end
    endtask

    task automatic test_done();
        rd_en = 1'b1;
        send(3'd2, 16'h0001, 32'h0, 16'h0, 32'hFFFFFFFF, 16'h0);
        @(negedge CLK);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            if (!empty) begin
                vectors++;
                if (dout !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL done_word: dout=%h want %h", dout, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            @(negedge CLK);
        end
        vectors++;
        if (exp_q.size() != 0 || full !== 1'b0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL done_release: left=%0d full=%b empty=%b want 0 0 1",
                     exp_q.size(), full, empty);
            exp_q.delete();
        end
    endtask

    task automatic test_invalid_type();
        rd_en = 1'b1;
        send(3'd5, 16'h7777, 32'h1, 16'h2, 32'h3, 16'h4);
        vectors++;
        if (full !== 1'b0 || err_type !== 1'b1) begin
            miscompares++;
            $display("FAIL inv_capture: full=%b err=%b want 0 1", full, err_type);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            vectors++;
            if (empty !== 1'b1 || err_type !== 1'b1) begin
                miscompares++;
                $display("FAIL inv_idle: empty=%b err=%b want 1 1", empty, err_type);
            end
        end
        test_done();
    endtask

    task automatic test_stalls();
        send(3'd1, 16'h1234, 32'hAABBCCDD, 16'h0005, 32'h0, 16'h0003);
        @(negedge CLK);
        for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
            rd_en = 1'($urandom_range(0, 1));
            if (c == 4) begin
                vectors++;
                if (full !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_full: full=%b want 1", full);
                end
                wr_en = 1'b1; pkt_type = 3'd2; pkt_id = 16'hDEAD;
                num_processed = 32'h12345678;
            end else begin
                wr_en = 1'b0;
            end
            if (!empty) begin
                vectors++;
                if (dout !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL stall_word: dout=%h want %h rd_en=%b",
                             dout, exp_q[0], rd_en);
                end
                if (rd_en) void'(exp_q.pop_front());
            end
            @(negedge CLK);
        end
        wr_en = 1'b0;
        rd_en = 1'b1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_timeout: left=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            vectors++;
            if (empty !== 1'b1 || full !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_extra: empty=%b full=%b want 1 0", empty, full);
            end
        end
    endtask

    task automatic test_back_to_back();
        rd_en = 1'b1;
        send(3'd2, 16'h0A0A, 32'h0, 16'h0, 32'h00010002, 16'h0);
        @(negedge CLK);
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            if (!empty) begin
                vectors++;
                if (dout !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL b2b_first: dout=%h want %h", dout, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            @(negedge CLK);
        end
        vectors++;
        if (full !== 1'b0 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_fall: full=%b left=%0d want 0 0", full, exp_q.size());
            exp_q.delete();
        end
        send(3'd1, 16'hBEEF, 32'h01234567, 16'h89AB, 32'h0, 16'hFFFF);
        @(negedge CLK);
        vectors++;
        if (empty !== 1'b0 || dout !== 16'hD402) begin
            miscompares++;
            $display("FAIL b2b_w0: empty=%b dout=%h want 0 d402", empty, dout);
        end
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            if (!empty) begin
                vectors++;
                if (dout !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL b2b_second: dout=%h want %h", dout, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            @(negedge CLK);
        end
        vectors++;
        if (exp_q.size() != 0 || empty !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_end: left=%0d empty=%b want 0 1", exp_q.size(), empty);
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int popped;
        popped = 0;
        rd_en = 1'b1;
        vectors++;
        if (err_type !== 1'b1) begin
            miscompares++;
            $display("FAIL rstmid_sticky: err=%b want 1", err_type);
        end
        send(3'd1, 16'h5555, 32'hCAFEF00D, 16'h0042, 32'h0, 16'h0009);
        @(negedge CLK);
        for (int c = 0; c < 20 && popped < 5; c++) begin
            if (!empty) begin
                vectors++;
                if (dout !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL rstmid_word: dout=%h want %h", dout, exp_q[0]);
                end
                void'(exp_q.pop_front());
                popped++;
            end
            @(negedge CLK);
        end
        rd_en = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if (empty !== 1'b1 || full !== 1'b0 || err_type !== 1'b0 || dout !== 16'h0) begin
            miscompares++;
            $display("FAIL rstmid_clear: empty=%b full=%b err=%b dout=%h want 1 0 0 0000",
                     empty, full, err_type, dout);
        end
        exp_q.delete();
        @(negedge CLK);
        rst = 1'b0;
        @(negedge CLK);
        rd_en = 1'b1;
        send(3'd2, 16'h0F0F, 32'h0, 16'h0, 32'h80000001, 16'h0);
        @(negedge CLK);
        vectors++;
        if (empty !== 1'b0 || dout !== 16'hD202) begin
            miscompares++;
            $display("FAIL rstmid_w0: empty=%b dout=%h want 0 d202", empty, dout);
        end
        for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
            if (!empty) begin
                vectors++;
                if (dout !== exp_q[0]) begin
                    miscompares++;
                    $display("FAIL rstmid_after: dout=%h want %h", dout, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
            @(negedge CLK);
        end
        vectors++;
        if (exp_q.size() != 0 || full !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_end: left=%0d full=%b want 0 0", exp_q.size(), full);
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_cmp_equal();
        test_done();
        test_invalid_type();
        test_stalls();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
